// File: rtl/reg_file_mp_sb.sv
// Multi-port register file for the pipelined CPU.
// Two write ports (A: ALU write-back, B: load/JAL write-back; B wins on a
// same-address collision), NREAD combinational read ports with optional
// same-cycle write forwarding, and a per-register busy scoreboard.
// A scoreboard bit is set when decode issues a writer and cleared when that
// register is written back. BusyCnt is a registered population count of the
// busy bits.
module reg_file_mp_sb #(
    parameter int DSIZE    = 16,
    parameter int RSIZE    = 4,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   WenA,
    input  logic [RSIZE-1:0]       WAddrA,
    input  logic [DSIZE-1:0]       WDataA,
    input  logic                   WenB,
    input  logic [RSIZE-1:0]       WAddrB,
    input  logic [DSIZE-1:0]       WDataB,
    input  logic [NREAD*RSIZE-1:0] RAddr,
    output logic [NREAD*DSIZE-1:0] RData,
    output logic [NREAD-1:0]       RBusy,
    input  logic                   IssueEn,
    input  logic [RSIZE-1:0]       IssueAddr,
    output logic [RSIZE:0]         BusyCnt
);

    localparam int DEPTH = 2 ** RSIZE;

    logic [DSIZE-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_next_s;
    logic [RSIZE:0]   busy_cnt_r;
    logic             wa_ok_s;
    logic             wb_ok_s;
    logic             iss_ok_s;

    // Number of set bits in a busy vector.
    function automatic logic [RSIZE:0] popcnt(input logic [DEPTH-1:0] v);
        logic [RSIZE:0] sum;
        sum = '0;
        for (int k = 0; k < DEPTH; k++) begin
            sum = sum + {{RSIZE{1'b0}}, v[k]};
        end
        return sum;
    endfunction

    // Qualify writes and issues: with a hard-wired R0 they never touch R0.
    always_comb begin
        wa_ok_s  = WenA    && !((ZERO_REG != 0) && (WAddrA    == '0));
        wb_ok_s  = WenB    && !((ZERO_REG != 0) && (WAddrB    == '0));
        iss_ok_s = IssueEn && !((ZERO_REG != 0) && (IssueAddr == '0));
    end

    // Storage update; port B is written last so it wins a same-address collision.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_r[k] <= '0;
            end
        end else begin
            if (wa_ok_s) begin
                regs_r[WAddrA] <= WDataA;
            end
            if (wb_ok_s) begin
                regs_r[WAddrB] <= WDataB;
            end
        end
    end

    // Next scoreboard state: write-back clears, issue sets, issue has the last word.
    always_comb begin
        busy_next_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            busy_next_s[k] = (iss_ok_s && (IssueAddr == k[RSIZE-1:0])) ||
                             (busy_r[k] &&
                              !((wa_ok_s && (WAddrA == k[RSIZE-1:0])) ||
                                (wb_ok_s && (WAddrB == k[RSIZE-1:0]))));
        end
    end

    // Scoreboard and its population count advance together on the same edge.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            busy_r     <= '0;
            busy_cnt_r <= '0;
        end else begin
            busy_r     <= busy_next_s;
            busy_cnt_r <= popcnt(busy_next_s);
        end
    end

    assign BusyCnt = busy_cnt_r;

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [RSIZE-1:0] addr_s;
        logic [DSIZE-1:0] data_s;
        logic             busy_s;

        assign addr_s = RAddr[g*RSIZE +: RSIZE];

        // Read mux: reset blanking, hard-wired R0, forwarding (B before A), then storage.
        always_comb begin
            data_s = regs_r[addr_s];
            busy_s = busy_r[addr_s];
            if (!Reset) begin
                data_s = '0;
                busy_s = 1'b0;
            end else if ((ZERO_REG != 0) && (addr_s == '0)) begin
                data_s = '0;
                busy_s = 1'b0;
            end else if ((BYPASS != 0) && wb_ok_s && (WAddrB == addr_s)) begin
                data_s = WDataB;
                busy_s = 1'b0;
            end else if ((BYPASS != 0) && wa_ok_s && (WAddrA == addr_s)) begin
                data_s = WDataA;
                busy_s = 1'b0;
            end else begin
                data_s = regs_r[addr_s];
                busy_s = busy_r[addr_s];
            end
        end

        assign RData[g*DSIZE +: DSIZE] = data_s;
        assign RBusy[g]                = busy_s;
    end

endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Bench for reg_file_mp_sb: one instance with forwarding, one without, driven
// by the same stimulus. Hand-written vectors cover the directed scenarios;
// a random phase is checked against a small behavioural model.
module tb_reg_file_mp_sb;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        WenA, WenB, IssueEn;
    logic [3:0]  WAddrA, WAddrB, IssueAddr;
    logic [15:0] WDataA, WDataB;
    logic [7:0]  RAddr;
    logic [31:0] rdata_b1, rdata_b0;
    logic [1:0]  rbusy_b1, rbusy_b0;
    logic [4:0]  cnt_b1, cnt_b0;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    reg_file_mp_sb #(.DSIZE(16), .RSIZE(4), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_b1 (
        .Clock(Clock), .Reset(Reset),
        .WenA(WenA), .WAddrA(WAddrA), .WDataA(WDataA),
        .WenB(WenB), .WAddrB(WAddrB), .WDataB(WDataB),
        .RAddr(RAddr), .RData(rdata_b1), .RBusy(rbusy_b1),
        .IssueEn(IssueEn), .IssueAddr(IssueAddr), .BusyCnt(cnt_b1)
    );

    reg_file_mp_sb #(.DSIZE(16), .RSIZE(4), .NREAD(2), .ZERO_REG(1), .BYPASS(0)) dut_b0 (
        .Clock(Clock), .Reset(Reset),
        .WenA(WenA), .WAddrA(WAddrA), .WDataA(WDataA),
        .WenB(WenB), .WAddrB(WAddrB), .WDataB(WDataB),
        .RAddr(RAddr), .RData(rdata_b0), .RBusy(rbusy_b0),
        .IssueEn(IssueEn), .IssueAddr(IssueAddr), .BusyCnt(cnt_b0)
    );

    typedef struct {
        logic        rst;
        logic        wena;  logic [3:0] wa; logic [15:0] da;
        logic        wenb;  logic [3:0] wb; logic [15:0] db;
        logic [3:0]  ra0;   logic [3:0] ra1;
        logic        iss;   logic [3:0] ia;
        logic [15:0] e_rd0_b1; logic e_bz0_b1;
        logic [15:0] e_rd0_b0; logic e_bz0_b0;
        logic [15:0] e_rd1;    logic e_bz1;
        logic [4:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [15:0] rd0_b1, rd1_b1, rd0_b0, rd1_b0;
        logic        bz0_b1, bz1_b1, bz0_b0, bz1_b0;
        logic [4:0]  cnt;
    } exp_t;

    exp_t sbq[$];

    logic [15:0] mem_m [16];
    logic [15:0] busy_m;

    function automatic vec_t mk(
        input logic rst, input logic wena, input logic [3:0] wa, input logic [15:0] da,
        input logic wenb, input logic [3:0] wb, input logic [15:0] db,
        input logic [3:0] ra0, input logic [3:0] ra1, input logic iss, input logic [3:0] ia,
        input logic [15:0] rd0b1, input logic bz0b1, input logic [15:0] rd0b0, input logic bz0b0,
        input logic [15:0] rd1, input logic bz1, input logic [4:0] cnt);
        vec_t v;
        v.rst = rst; v.wena = wena; v.wa = wa; v.da = da;
        v.wenb = wenb; v.wb = wb; v.db = db;
        v.ra0 = ra0; v.ra1 = ra1; v.iss = iss; v.ia = ia;
        v.e_rd0_b1 = rd0b1; v.e_bz0_b1 = bz0b1;
        v.e_rd0_b0 = rd0b0; v.e_bz0_b0 = bz0b0;
        v.e_rd1 = rd1; v.e_bz1 = bz1; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference read for the currently driven inputs.
    function automatic void model_read(input logic [3:0] a, input bit byp,
                                       output logic [15:0] d, output logic b);
        if (!Reset) begin
            d = 16'h0000; b = 1'b0;
        end else if (a == 4'd0) begin
            d = 16'h0000; b = 1'b0;
        end else if (byp && WenB && WAddrB == a) begin
            d = WDataB; b = 1'b0;
        end else if (byp && WenA && WAddrA == a) begin
            d = WDataA; b = 1'b0;
        end else begin
            d = mem_m[a]; b = busy_m[a];
        end
    endfunction

    // Advance the reference state by one clock edge; returns the new busy count.
    function automatic logic [4:0] model_step();
        logic [4:0] c;
        if (!Reset) begin
            for (int k = 0; k < 16; k++) mem_m[k] = 16'h0000;
            busy_m = 16'h0000;
        end else begin
            if (WenA && WAddrA != 4'd0) begin mem_m[WAddrA] = WDataA; busy_m[WAddrA] = 1'b0; end
            if (WenB && WAddrB != 4'd0) begin mem_m[WAddrB] = WDataB; busy_m[WAddrB] = 1'b0; end
            if (IssueEn && IssueAddr != 4'd0) busy_m[IssueAddr] = 1'b1;
        end
        c = 5'd0;
        for (int k = 0; k < 16; k++) c = c + {4'd0, busy_m[k]};
        return c;
    endfunction

    task automatic drive(input vec_t v);
        Reset = v.rst;
        WenA = v.wena; WAddrA = v.wa; WDataA = v.da;
        WenB = v.wenb; WAddrB = v.wb; WDataB = v.db;
        RAddr = {v.ra1, v.ra0};
        IssueEn = v.iss; IssueAddr = v.ia;
    endtask

    // One cycle: drive at negedge, check reads mid-cycle, check count after the edge.
    task automatic run_cycle(input vec_t v, input bit use_model, input string tag);
        exp_t e;
        exp_t g;
        logic [4:0] c;
        @(negedge Clock);
        drive(v);
        #1;
        if (use_model) begin
            model_read(v.ra0, 1'b1, e.rd0_b1, e.bz0_b1);
            model_read(v.ra1, 1'b1, e.rd1_b1, e.bz1_b1);
            model_read(v.ra0, 1'b0, e.rd0_b0, e.bz0_b0);
            model_read(v.ra1, 1'b0, e.rd1_b0, e.bz1_b0);
        end else begin
            e.rd0_b1 = v.e_rd0_b1; e.bz0_b1 = v.e_bz0_b1;
            e.rd0_b0 = v.e_rd0_b0; e.bz0_b0 = v.e_bz0_b0;
            e.rd1_b1 = v.e_rd1;    e.bz1_b1 = v.e_bz1;
            e.rd1_b0 = v.e_rd1;    e.bz1_b0 = v.e_bz1;
        end
        c = model_step();
        e.cnt = use_model ? c : v.e_cnt;
        sbq.push_back(e);
        #1;
        g = sbq.pop_front();
        chk({tag, " rd0_byp"},   rdata_b1[15:0],  g.rd0_b1);
        chk({tag, " rd1_byp"},   rdata_b1[31:16], g.rd1_b1);
        chk({tag, " bz0_byp"},   {15'd0, rbusy_b1[0]}, {15'd0, g.bz0_b1});
        chk({tag, " bz1_byp"},   {15'd0, rbusy_b1[1]}, {15'd0, g.bz1_b1});
        chk({tag, " rd0_nobyp"}, rdata_b0[15:0],  g.rd0_b0);
        chk({tag, " rd1_nobyp"}, rdata_b0[31:16], g.rd1_b0);
        chk({tag, " bz0_nobyp"}, {15'd0, rbusy_b0[0]}, {15'd0, g.bz0_b0});
        chk({tag, " bz1_nobyp"}, {15'd0, rbusy_b0[1]}, {15'd0, g.bz1_b0});
        @(posedge Clock);
        #1;
        chk({tag, " cnt_byp"},   {11'd0, cnt_b1}, {11'd0, g.cnt});
        chk({tag, " cnt_nobyp"}, {11'd0, cnt_b0}, {11'd0, g.cnt});
    endtask

    initial begin
        vec_t tbl [19];
        vec_t v;

        tbl[0]  = mk(1,1,3,16'hBEEF,0,0,16'h0,3,0,0,0, 16'hBEEF,0,16'h0000,0, 16'h0000,0, 5'd0);
        tbl[1]  = mk(1,0,0,16'h0,0,0,16'h0,3,3,0,0,     16'hBEEF,0,16'hBEEF,0, 16'hBEEF,0, 5'd0);
        tbl[2]  = mk(1,1,5,16'h1111,1,5,16'h2222,5,3,0,0, 16'h2222,0,16'h0000,0, 16'hBEEF,0, 5'd0);
        tbl[3]  = mk(1,1,0,16'hFFFF,0,0,16'h0,0,5,0,0,  16'h0000,0,16'h0000,0, 16'h2222,0, 5'd0);
        tbl[4]  = mk(1,0,0,16'h0,0,0,16'h0,0,5,0,0,     16'h0000,0,16'h0000,0, 16'h2222,0, 5'd0);
        tbl[5]  = mk(1,0,0,16'h0,0,0,16'h0,7,0,1,7,     16'h0000,0,16'h0000,0, 16'h0000,0, 5'd1);
        tbl[6]  = mk(1,0,0,16'h0,0,0,16'h0,7,0,0,0,     16'h0000,1,16'h0000,1, 16'h0000,0, 5'd1);
        tbl[7]  = mk(1,0,0,16'h0,1,7,16'h0042,7,0,0,0,  16'h0042,0,16'h0000,1, 16'h0000,0, 5'd0);
        tbl[8]  = mk(1,0,0,16'h0,0,0,16'h0,7,0,0,0,     16'h0042,0,16'h0042,0, 16'h0000,0, 5'd0);
        tbl[9]  = mk(1,1,9,16'h9999,0,0,16'h0,9,0,1,9,  16'h9999,0,16'h0000,0, 16'h0000,0, 5'd1);
        tbl[10] = mk(1,0,0,16'h0,0,0,16'h0,9,0,0,0,     16'h9999,1,16'h9999,1, 16'h0000,0, 5'd1);
        tbl[11] = mk(1,0,0,16'h0,0,0,16'h0,0,9,1,0,     16'h0000,0,16'h0000,0, 16'h9999,1, 5'd1);
        tbl[12] = mk(1,0,0,16'h0,0,0,16'h0,9,0,1,9,     16'h9999,1,16'h9999,1, 16'h0000,0, 5'd1);
        tbl[13] = mk(1,1,4,16'h0004,0,0,16'h0,4,9,1,2,  16'h0004,0,16'h0000,0, 16'h9999,1, 5'd2);
        tbl[14] = mk(1,0,0,16'h0,0,0,16'h0,2,9,1,4,     16'h0000,1,16'h0000,1, 16'h9999,1, 5'd3);
        tbl[15] = mk(1,0,9,16'hDEAD,0,9,16'hBEEF,9,4,0,0, 16'h9999,1,16'h9999,1, 16'h0004,1, 5'd3);
        tbl[16] = mk(0,1,4,16'hABCD,0,0,16'h0,4,2,1,6,  16'h0000,0,16'h0000,0, 16'h0000,0, 5'd0);
        tbl[17] = mk(1,0,0,16'h0,0,0,16'h0,4,3,0,0,     16'h0000,0,16'h0000,0, 16'h0000,0, 5'd0);
        tbl[18] = mk(1,0,0,16'h0,0,0,16'h0,9,2,0,0,     16'h0000,0,16'h0000,0, 16'h0000,0, 5'd0);

        // Two reset cycles with activity on the write/issue ports.
        v = mk(0,1,6,16'h5A5A,1,8,16'hA5A5,0,0,1,6, 16'h0,0,16'h0,0, 16'h0,0, 5'd0);
        drive(v);
        for (int k = 0; k < 16; k++) mem_m[k] = 16'h0000;
        busy_m = 16'h0000;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset cnt_byp",   {11'd0, cnt_b1}, 16'h0000);
        chk("reset cnt_nobyp", {11'd0, cnt_b0}, 16'h0000);

        // Every address reads as zero and not busy after reset.
        for (int a = 0; a < 16; a++) begin
            v = mk(1,0,0,16'h0,0,0,16'h0,a[3:0],4'(15 - a),0,0,
                   16'h0,0,16'h0,0, 16'h0,0, 5'd0);
            run_cycle(v, 1'b0, "post_reset");
        end

        // Directed scenarios.
        for (int i = 0; i < 19; i++) begin
            run_cycle(tbl[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            v = mk(($urandom_range(0, 49) != 0),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   16'h0,0,16'h0,0, 16'h0,0, 5'd0);
            // Bias read addresses onto write targets so forwarding is exercised.
            if ($urandom_range(0, 2) == 0) v.ra0 = v.wa;
            if ($urandom_range(0, 2) == 0) v.ra1 = v.wb;
            run_cycle(v, 1'b1, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
